dcache_nway: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_way.sv | 61 ++++++
 rtl/dcache_nway.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_nway.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-width helpers for the N-way data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_t;

  localparam logic ADDR_WORD = 1'b0;
  localparam logic ADDR_BYTE = 1'b1;

  function automatic int offset_bits(input int line_words, input int data_width);
    return $clog2(line_words * data_width / 8);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int line_words,
                                  input int data_width, input int sets);
    return addr_width - offset_bits(line_words, data_width) - index_bits(sets);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid/dirty/tag/data arrays and the tag compare.
// Only valid and dirty are reset; tag and data come up undefined.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = 6,
  localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 hit_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 store_en_i,
  input  logic [LINE_BITS-1:0] store_mask_i,
  input  logic [LINE_BITS-1:0] store_line_i,
  input  logic                 fill_en_i,
  input  logic [LINE_BITS-1:0] fill_line_i
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (store_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (store_en_i) begin
      data_q[idx_i] <= (data_q[idx_i] & ~store_mask_i) | (store_line_i & store_mask_i);
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
  assign hit_o   = valid_o && (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache: victim select, FSM, memory mux.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
//   state     | meaning
//   LOOKUP    | tag compare; hits serviced, misses pick a victim
//   WRITEBACK | dirty victim line being written to memory
//   REFILL    | requested line being fetched and installed
module dcache_nway
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  AddrMode,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [LINE_BITS-1:0]  mem_writedata,
  input  logic [LINE_BITS-1:0]  mem_readdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W  = offset_bits(LINE_WORDS, DATA_WIDTH);
  localparam int IDX_W  = index_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, LINE_WORDS, DATA_WIDTH, SETS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int WSEL_W = OFF_W - BYTE_W;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [BYTE_W-1:0] bsel;
  logic              access;

  assign idx    = data_address[OFF_W +: IDX_W];
  assign tag    = data_address[ADDR_WIDTH-1 -: TAG_W];
  assign wsel   = data_address[BYTE_W +: WSEL_W];
  assign bsel   = data_address[BYTE_W-1:0];
  assign access = MemRead | MemWrite;

  logic [WAYS-1:0]      hit_w, valid_w, dirty_w;
  logic [TAG_W-1:0]     tag_w  [WAYS];
  logic [LINE_BITS-1:0] line_w [WAYS];

  dcache_state_t    state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d, victim;
  logic [WAY_W-1:0] rr_q [SETS];
  logic             victim_found, hit_any, stall_c, store_en, fill_en, rr_adv;
  logic [LINE_BITS-1:0]  hit_line, store_mask, store_line;
  logic [DATA_WIDTH-1:0] wmask, wdata, rd_word;
  logic [7:0]            rd_byte;

  // Byte stores replicate the byte across the word and rely on the mask.
  assign wmask = (AddrMode == ADDR_BYTE) ? ({{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {bsel, 3'b000})
                                         : '1;
  assign wdata = (AddrMode == ADDR_BYTE) ? {NBYTES{write_data[7:0]}} : write_data;
  assign store_mask = {{(LINE_BITS-DATA_WIDTH){1'b0}}, wmask} << (wsel * DATA_WIDTH);
  assign store_line = {{(LINE_BITS-DATA_WIDTH){1'b0}}, wdata} << (wsel * DATA_WIDTH);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way #(
      .DATA_WIDTH(DATA_WIDTH),
      .LINE_WORDS(LINE_WORDS),
      .SETS      (SETS),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .idx_i       (idx),
      .tag_i       (tag),
      .hit_o       (hit_w[g]),
      .valid_o     (valid_w[g]),
      .dirty_o     (dirty_w[g]),
      .tag_o       (tag_w[g]),
      .line_o      (line_w[g]),
      .store_en_i  (store_en && hit_w[g]),
      .store_mask_i(store_mask),
      .store_line_i(store_line),
      .fill_en_i   (fill_en && (victim_q == WAY_W'(g))),
      .fill_line_i (mem_readdata)
    );
  end

  always_comb begin
    hit_any      = |hit_w;
    hit_line     = '0;
    victim       = rr_q[idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_w[w]) hit_line = line_w[w];
      if (!victim_found && !valid_w[w]) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign rd_word = hit_line[wsel*DATA_WIDTH +: DATA_WIDTH];
  assign rd_byte = rd_word[{bsel, 3'b000} +: 8];

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    stall_c        = 1'b0;
    mem_req        = 1'b0;
    WriteEnable    = 1'b0;
    memory_address = '0;
    mem_writedata  = '0;
    store_en       = 1'b0;
    fill_en        = 1'b0;
    rr_adv         = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (access) begin
          if (hit_any) begin
            store_en = MemWrite;
          end else begin
            stall_c  = 1'b1;
            victim_d = victim;
            state_d  = (valid_w[victim] && dirty_w[victim]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall_c        = 1'b1;
        mem_req        = 1'b1;
        WriteEnable    = 1'b1;
        memory_address = {tag_w[victim_q], idx, {OFF_W{1'b0}}};
        mem_writedata  = line_w[victim_q];
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        stall_c        = 1'b1;
        mem_req        = 1'b1;
        memory_address = {tag, idx, {OFF_W{1'b0}}};
        if (mem_ready) begin
          fill_en = 1'b1;
          rr_adv  = 1'b1;
          state_d = LOOKUP;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  // Reset must silence the pipeline-facing outputs even while a miss is presented.
  assign stall     = rst & stall_c;
  assign read_data = (rst && state_q == LOOKUP && hit_any && MemRead && !MemWrite)
                     ? ((AddrMode == ADDR_BYTE) ? {{(DATA_WIDTH-8){1'b0}}, rd_byte} : rd_word)
                     : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOOKUP;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (rr_adv) begin
      rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  logic retry_q;

  // The lookup right after a refill belongs to the same access and is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      retry_q    <= 1'b0;
    end else begin
      if (state_q == REFILL && mem_ready) retry_q <= 1'b1;
      else if (state_q == LOOKUP)         retry_q <= 1'b0;
      if (state_q == LOOKUP && access && !retry_q) begin
        if (hit_any) begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway: behavioural cache/memory model plus directed scenarios.
module tb_dcache_nway;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  data_address = '0, write_data = '0;
  logic         MemWrite = 1'b0, MemRead = 1'b0, AddrMode = 1'b0;
  logic [31:0]  read_data;
  logic         stall, mem_req, WriteEnable;
  logic [31:0]  memory_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;
  logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_nway dut (
    .clk           (clk),
    .rst           (rst),
    .data_address  (data_address),
    .write_data    (write_data),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .AddrMode      (AddrMode),
    .read_data     (read_data),
    .stall         (stall),
    .mem_req       (mem_req),
    .WriteEnable   (WriteEnable),
    .memory_address(memory_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_ready     (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = (la + 32'(i*4)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  // Memory seen by the DUT, and the model's own copy of memory.
  logic [127:0] ram   [logic [31:0]];
  logic [127:0] ram_m [logic [31:0]];

  function automatic logic [127:0] ram_get(input logic [31:0] la);
    if (ram.exists(la)) return ram[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] m_get(input logic [31:0] la);
    if (ram_m.exists(la)) return ram_m[la];
    return init_line(la);
  endfunction

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } txn_t;
  txn_t exp_q[$];
  txn_t popped;

  // Cache model: 64 sets x 2 ways, round-robin replacement.
  bit           m_valid [64][2];
  bit           m_dirty [64][2];
  logic [21:0]  m_tag   [64][2];
  logic [127:0] m_line  [64][2];
  int           m_rr    [64];

  int          exp_stall;
  bit          exp_wb;
  bit          exp_chk_rd;
  logic [31:0] exp_rdata;

  task automatic m_clear();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                       input bit bm);
    int s, h, v, wi, bi;
    logic [21:0]  t;
    logic [31:0]  la, word;
    txn_t         tx;
    s  = int'(a[9:4]);
    t  = a[31:10];
    wi = int'(a[3:2]);
    bi = int'(a[1:0]);
    exp_stall  = 0;
    exp_wb     = 1'b0;
    exp_rdata  = '0;
    exp_chk_rd = !wr;
    if (!rd && !wr) return;
    h = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) h = w;
    if (h < 0) begin
      v = -1;
      for (int w = 0; w < 2; w++) if (v < 0 && !m_valid[s][w]) v = w;
      if (v < 0) v = m_rr[s];
      exp_stall = 4;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        exp_wb    = 1'b1;
        exp_stall = 7;
        tx.we     = 1'b1;
        tx.addr   = {m_tag[s][v], 6'(s), 4'b0000};
        tx.data   = m_line[s][v];
        exp_q.push_back(tx);
        ram_m[tx.addr] = m_line[s][v];
      end
      la      = {a[31:4], 4'b0000};
      tx.we   = 1'b0;
      tx.addr = la;
      tx.data = '0;
      exp_q.push_back(tx);
      m_line[s][v]  = m_get(la);
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b0;
      m_tag[s][v]   = t;
      m_rr[s]       = (m_rr[s] + 1) % 2;
      h = v;
    end
    word = m_line[s][h][wi*32 +: 32];
    if (wr) begin
      if (bm) word[bi*8 +: 8] = wd[7:0];
      else    word = wd;
      m_line[s][h][wi*32 +: 32] = word;
      m_dirty[s][h] = 1'b1;
    end else begin
      exp_rdata = bm ? {24'b0, word[bi*8 +: 8]} : word;
    end
  endtask

  // Per-cycle compare of the pipeline/memory-control outputs during an access.
  bit          cur_active = 1'b0;
  bit          done = 1'b0;
  int          cyc = 0;
  int          stall_cnt = 0;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    if (cur_active && !done && rst) begin
      chk("stall", stall, cyc < exp_stall);
      chk("mem_req", mem_req, (cyc >= 1) && (cyc < exp_stall));
      chk("write_enable", WriteEnable, exp_wb && (cyc >= 1) && (cyc <= 3));
      if (stall) stall_cnt++;
      if (cyc >= exp_stall) begin
        if (exp_chk_rd) chk("read_data", read_data, exp_rdata);
        chk("txn_pending", exp_q.size(), 0);
        last_rdata = read_data;
        done = 1'b1;
      end
      cyc++;
    end
  end

  // Memory responder: ready in the third cycle of each request; checks each transaction.
  int           mcnt = 0;
  int           wb_seen = 0;
  logic [31:0]  cap_addr;
  logic         cap_we;
  logic [127:0] cap_wd;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mcnt = 0;
      mem_ready = 1'b0;
      mem_readdata = '0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        mcnt = 0;
      end
      if (mem_req) begin
        mcnt++;
        if (mcnt == 1) begin
          cap_addr = memory_address;
          cap_we   = WriteEnable;
          cap_wd   = mem_writedata;
        end else begin
          chk("req_addr_stable", memory_address, cap_addr);
          chk("req_we_stable", WriteEnable, cap_we);
          if (cap_we) chk("wb_data_stable", mem_writedata, cap_wd);
        end
        if (mcnt == 3) begin
          mem_ready = 1'b1;
          if (WriteEnable) begin
            ram[memory_address] = mem_writedata;
            wb_seen++;
          end else begin
            mem_readdata = ram_get(memory_address);
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", mem_req, 1'b0);
          end else begin
            popped = exp_q.pop_front();
            chk("txn_we", WriteEnable, popped.we);
            chk("txn_addr", memory_address, popped.addr);
            if (popped.we) chk("wb_data", mem_writedata, popped.data);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                        input bit bm);
    model(a, wd, rd, wr, bm);
    data_address = a;
    write_data   = wd;
    MemRead      = rd;
    MemWrite     = wr;
    AddrMode     = bm;
    cyc        = 0;
    stall_cnt  = 0;
    done       = 1'b0;
    cur_active = 1'b1;
    for (int i = 0; i < 40 && !done; i++) @(posedge clk);
    if (!done) chk("access_timeout", done, 1'b1);
    #1;
    cur_active = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [127:0] tmp;
  int           wb0;

  initial begin
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    data_address = 32'h100;
    MemRead = 1'b1;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_we", WriteEnable, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold word load, then a hit in the same line.
    access(32'h100, 32'h0, 1, 0, 0);
    chk("s1_rdata", last_rdata, 32'hC0DE_0100);
    chk("s1_stall_cycles", stall_cnt, 4);
    access(32'h104, 32'h0, 1, 0, 0);
    chk("s1_hit_rdata", last_rdata, 32'hC0DE_0104);
    chk("s1_hit_stall", stall_cnt, 0);
`ifdef DCACHE_STATS_EN
    chk("stats_miss", miss_count, 32'd1);
    chk("stats_hit", hit_count, 32'd1);
`endif

    // Byte store then word/byte loads.
    access(32'h101, 32'hFFFF_FFAB, 0, 1, 1);
    access(32'h100, 32'h0, 1, 0, 0);
    chk("s2_word", last_rdata, 32'hC0DE_AB00);
    access(32'h101, 32'h0, 1, 0, 1);
    chk("s2_byte", last_rdata, 32'h0000_00AB);
    access(32'h103, 32'h0, 1, 0, 1);
    chk("s2_byte3", last_rdata, 32'h0000_00C0);
    access(32'h104, 32'h0, 0, 0, 0);

    // Dirty eviction in set 0x10.
    wb0 = wb_seen;
    access(32'h500, 32'h0, 1, 0, 0);
    access(32'h900, 32'h0, 1, 0, 0);
    chk("s3_stall_cycles", stall_cnt, 7);
    chk("s3_wb_count", wb_seen - wb0, 1);
    tmp = ram_get(32'h100);
    chk("s3_wb_word0", tmp[31:0], 32'hC0DE_AB00);
    chk("s3_rdata", last_rdata, 32'hC0DE_0900);

    // Store miss with both strobes high (write-allocate), then read back.
    access(32'h308, 32'h1234_5678, 1, 1, 0);
    access(32'h308, 32'h0, 1, 0, 0);
    chk("s3_alloc_rdata", last_rdata, 32'h1234_5678);

    // Clean eviction in set 0x20.
    wb0 = wb_seen;
    access(32'h200, 32'h0, 1, 0, 0);
    access(32'h600, 32'h0, 1, 0, 0);
    access(32'hA00, 32'h0, 1, 0, 0);
    chk("s4_wb_count", wb_seen - wb0, 0);
    access(32'hA04, 32'h5555_AAAA, 0, 1, 0);
    access(32'hA04, 32'h0, 1, 0, 0);
    chk("s4_store_word", last_rdata, 32'h5555_AAAA);

    // Reset mid-refill.
    access(32'h100, 32'h0, 1, 0, 0);
    data_address = 32'hC40;
    MemRead = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("s5_pre_req", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk("s5_rst_req", mem_req, 1'b0);
    chk("s5_rst_stall", stall, 1'b0);
    chk("s5_rst_we", WriteEnable, 1'b0);
    chk("s5_rst_rdata", read_data, 32'h0);
    MemRead = 1'b0;
    exp_q.delete();
    m_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(32'h100, 32'h0, 1, 0, 0);
    chk("s5_remiss_stall", stall_cnt, 4);
    chk("s5_remiss_rdata", last_rdata, 32'hC0DE_AB00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
